// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard constants: extended-key prefix, arrow scancode low bytes
// and the 2-bit direction encoding used by downstream control logic.
package kbd_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CODE_W = 16;
   localparam int unsigned DIR_W  = 2;

   localparam logic [BYTE_W-1:0] PREFIX     = 8'hE0;
   localparam logic [BYTE_W-1:0] CODE_LEFT  = 8'h6B;
   localparam logic [BYTE_W-1:0] CODE_DOWN  = 8'h72;
   localparam logic [BYTE_W-1:0] CODE_RIGHT = 8'h74;
   localparam logic [BYTE_W-1:0] CODE_UP    = 8'h75;

   typedef enum logic [DIR_W-1:0] {
      DIR_LEFT  = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_RIGHT = 2'd2,
      DIR_UP    = 2'd3
   } dir_t;

endpackage

// File: rtl/arrow_key_decoder.sv
// Decodes PS/2 extended arrow-key scancodes into one-hot combinational flags and
// keeps registered status: last arrow direction, valid flag and a saturating count.
module arrow_key_decoder #(
   parameter logic [7:0]  PREFIX     = kbd_pkg::PREFIX,
   parameter logic [7:0]  CODE_LEFT  = kbd_pkg::CODE_LEFT,
   parameter logic [7:0]  CODE_DOWN  = kbd_pkg::CODE_DOWN,
   parameter logic [7:0]  CODE_RIGHT = kbd_pkg::CODE_RIGHT,
   parameter logic [7:0]  CODE_UP    = kbd_pkg::CODE_UP,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      scancode,
   output logic             left,
   output logic             down,
   output logic             right,
   output logic             up,
   output logic             arrow_any,
   output logic [1:0]       last_dir,
   output logic             last_valid,
   output logic [CNT_W-1:0] arrow_cnt
);

   import kbd_pkg::*;

   localparam logic [15:0] KEY_LEFT  = {PREFIX, CODE_LEFT};
   localparam logic [15:0] KEY_DOWN  = {PREFIX, CODE_DOWN};
   localparam logic [15:0] KEY_RIGHT = {PREFIX, CODE_RIGHT};
   localparam logic [15:0] KEY_UP    = {PREFIX, CODE_UP};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   dir_t dir;

   // Full 16-bit compare; flags stay live during reset since they ignore clk/rst_n.
   always_comb begin
      left  = 1'b0;
      down  = 1'b0;
      right = 1'b0;
      up    = 1'b0;
      if (scancode == KEY_LEFT)  left  = 1'b1;
      if (scancode == KEY_DOWN)  down  = 1'b1;
      if (scancode == KEY_RIGHT) right = 1'b1;
      if (scancode == KEY_UP)    up    = 1'b1;
   end

   assign arrow_any = left | down | right | up;

   always_comb begin
      dir = DIR_LEFT;
      if (down)  dir = DIR_DOWN;
      if (right) dir = DIR_RIGHT;
      if (up)    dir = DIR_UP;
   end

   // Status registers only move on cycles where an arrow is present.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dir   <= 2'd0;
         last_valid <= 1'b0;
         arrow_cnt  <= '0;
      end else if (arrow_any) begin
         last_dir   <= 2'(dir);
         last_valid <= 1'b1;
         if (arrow_cnt != CNT_MAX) arrow_cnt <= arrow_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_arrow_key_decoder.sv
// Self-checking bench for arrow_key_decoder: vector table, reset/sequence/saturation
// corner cases and a randomized run against a behavioural model.
module tb_arrow_key_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] scancode;
   logic        left, down, right, up, arrow_any;
   logic [1:0]  last_dir;
   logic        last_valid;
   logic [15:0] arrow_cnt;

   logic        rst2_n;
   logic [15:0] sc2;
   logic        l2, d2, r2, u2, any2;
   logic [1:0]  dir2;
   logic        valid2;
   logic [1:0]  cnt2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   arrow_key_decoder dut (
      .clk(clk), .rst_n(rst_n), .scancode(scancode),
      .left(left), .down(down), .right(right), .up(up), .arrow_any(arrow_any),
      .last_dir(last_dir), .last_valid(last_valid), .arrow_cnt(arrow_cnt)
   );

   arrow_key_decoder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .scancode(sc2),
      .left(l2), .down(d2), .right(r2), .up(u2), .arrow_any(any2),
      .last_dir(dir2), .last_valid(valid2), .arrow_cnt(cnt2)
   );

   typedef struct {
      logic [15:0] sc;
      logic [3:0]  flags;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written from the scancode table: {left,down,right,up}.
   function automatic logic [3:0] ref_flags(input logic [15:0] s);
      logic [3:0] f;
      f = 4'b0000;
      if (s[15:8] == 8'hE0) begin
         case (s[7:0])
            8'h6B:   f = 4'b1000;
            8'h72:   f = 4'b0100;
            8'h74:   f = 4'b0010;
            8'h75:   f = 4'b0001;
            default: f = 4'b0000;
         endcase
      end
      return f;
   endfunction

   function automatic logic [1:0] ref_dir(input logic [3:0] f);
      for (int i = 0; i < 4; i++)
         if (f[3-i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic chk_flags(input string name, input logic [3:0] exp);
      chk(name, {28'd0, left, down, right, up}, {28'd0, exp});
      chk({name, "_any"}, {31'd0, arrow_any}, {31'd0, |exp});
   endtask

   task automatic chk_regs(input string name, input logic [1:0] d, input logic v,
                           input logic [15:0] c);
      chk({name, "_dir"},   {30'd0, last_dir},   {30'd0, d});
      chk({name, "_valid"}, {31'd0, last_valid}, {31'd0, v});
      chk({name, "_cnt"},   {16'd0, arrow_cnt},  {16'd0, c});
   endtask

   vec_t vecs[13];
   logic [1:0]  m_dir;
   logic        m_valid;
   logic [15:0] m_cnt;
   logic [3:0]  f;
   logic [1:0]  sat_exp[5];

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      scancode = 16'h0000; sc2 = 16'h0000;

      vecs[0]  = '{16'h0000, 4'b0000};
      vecs[1]  = '{16'h0001, 4'b0000};
      vecs[2]  = '{16'hE075, 4'b0001};
      vecs[3]  = '{16'hE06B, 4'b1000};
      vecs[4]  = '{16'hE06C, 4'b0000};
      vecs[5]  = '{16'hE072, 4'b0100};
      vecs[6]  = '{16'hE074, 4'b0010};
      vecs[7]  = '{16'hE076, 4'b0000};
      vecs[8]  = '{16'hFFFF, 4'b0000};
      vecs[9]  = '{16'h006B, 4'b0000};
      vecs[10] = '{16'hE16B, 4'b0000};
      vecs[11] = '{16'hE000, 4'b0000};
      vecs[12] = '{16'h75E0, 4'b0000};

      #1;
      chk_regs("reset", 2'd0, 1'b0, 16'd0);

      // Combinational table, applied while held in reset.
      for (int i = 0; i < 13; i++) begin
         scancode = vecs[i].sc;
         #1;
         chk_flags($sformatf("vec%0d", i), vecs[i].flags);
      end

      // Reset held with an arrow present: flags live, registers frozen.
      @(negedge clk);
      scancode = 16'hE072;
      #1;
      chk_flags("rst_down", 4'b0100);
      @(posedge clk); #1;
      chk_regs("rst_hold", 2'd0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_regs("rst_rel", 2'd1, 1'b1, 16'd1);

      // Three-edge sequence E06B, 0000, E074.
      @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
      chk_regs("seq_rst", 2'd0, 1'b0, 16'd0);
      scancode = 16'hE06B;
      @(posedge clk); #1; chk_regs("seq1", 2'd0, 1'b1, 16'd1);
      @(negedge clk); scancode = 16'h0000;
      @(posedge clk); #1; chk_regs("seq2", 2'd0, 1'b1, 16'd1);
      @(negedge clk); scancode = 16'hE074;
      @(posedge clk); #1; chk_regs("seq3", 2'd2, 1'b1, 16'd2);

      // Two-bit counter saturation.
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
      @(negedge clk);
      rst2_n = 1'b1; sc2 = 16'hE075;
      #1;
      chk("sat_start", {30'd0, cnt2}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("sat%0d", i), {30'd0, cnt2}, {30'd0, sat_exp[i]});
      end
      chk("sat_dir", {30'd0, dir2}, 32'd3);
      chk("sat_up", {31'd0, u2}, 32'd1);

      // Randomized: scancode changes after both edges; model tracks registers.
      @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
      m_dir = 2'd0; m_valid = 1'b0; m_cnt = 16'd0;
      for (int n = 0; n < 15000; n++) begin
         @(posedge clk);
         f = ref_flags(scancode);
         if (f != 4'b0000) begin
            m_dir = ref_dir(f);
            m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         #2;
         chk_regs("rnd", m_dir, m_valid, m_cnt);
         for (int h = 0; h < 2; h++) begin
            if (h == 1) begin
               @(negedge clk); #2;
            end
            case ($urandom_range(0, 5))
               0:       scancode = 16'hE06B;
               1:       scancode = 16'hE072;
               2:       scancode = 16'hE074;
               3:       scancode = 16'hE075;
               4:       scancode = {8'hE0, 8'($urandom)};
               default: scancode = 16'($urandom);
            endcase
            #1;
            chk_flags("rnd_flags", ref_flags(scancode));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
